// File: rtl/clk_div_if.sv
// rtl/clk_div_if.sv - control and divided-clock bundle for clk_div
interface clk_div_if #(
  parameter int RATIO_WD = 8
);
  logic                clk_en;
  logic [RATIO_WD-1:0] div_ratio;
  logic                div_clk;

  modport master (output clk_en, output div_ratio, input  div_clk);
  modport slave  (input  clk_en, input  div_ratio, output div_clk);
endinterface

// File: rtl/clk_div.sv
// rtl/clk_div.sv - integer clock divider, 50% duty for even ratios, bypass when idle
// Ratio is latched only at period boundaries so DIV_CLK never has a truncated phase.
module clk_div #(
  parameter int RATIO_WD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  clk_div_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [RATIO_WD-1:0] r_cnt;
  logic [RATIO_WD-1:0] w_cnt_nxt;
  logic [RATIO_WD-1:0] r_ratio;
  logic [RATIO_WD-1:0] w_ratio_nxt;
  logic                r_div;
  logic                w_div_nxt;
  logic                w_start;
  logic [RATIO_WD-1:0] w_low_len;
  logic [RATIO_WD-1:0] w_high_len;

  assign w_start    = bus.clk_en && (bus.div_ratio >= RATIO_WD'(2));
  assign w_low_len  = r_ratio >> 1;
  assign w_high_len = r_ratio - w_low_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ratio <= '0;
      r_div   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      r_div   <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ratio_nxt = r_ratio;
    w_div_nxt   = r_div;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_LOW;
          w_ratio_nxt = bus.div_ratio;
          w_cnt_nxt   = '0;
          w_div_nxt   = 1'b0;
        end
      end
      ST_LOW: begin
        w_cnt_nxt = r_cnt + RATIO_WD'(1);
        if (r_cnt == w_low_len - RATIO_WD'(1)) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_div_nxt   = 1'b1;
        end
      end
      ST_HIGH: begin
        w_cnt_nxt = r_cnt + RATIO_WD'(1);
        if (r_cnt == w_high_len - RATIO_WD'(1)) begin
          // Period boundary: the only point where a new ratio or enable is honoured
          w_cnt_nxt = '0;
          w_div_nxt = 1'b0;
          if (w_start) begin
            w_state_nxt = ST_LOW;
            w_ratio_nxt = bus.div_ratio;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_div_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.div_clk = (r_state == ST_IDLE) ? i_clk : r_div;
  end

endmodule

// File: tb/tb_clk_div.sv
// tb/tb_clk_div.sv - randomized self-checking bench for clk_div against a period-position model
module tb_clk_div;

  localparam int RATIO_WD = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  clk_div_if #(.RATIO_WD(RATIO_WD)) dif ();

  clk_div #(.RATIO_WD(RATIO_WD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: either bypass, or running at position m_p (0..m_n-1) of an m_n-cycle period
  bit m_run;
  int m_n;
  int m_p;
  bit rst_req;

  task automatic check_val(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_model();
    if (!rst_n) begin
      m_run = 0;
    end else if (!m_run) begin
      if (dif.clk_en && dif.div_ratio >= 2) begin
        m_run = 1;
        m_n   = int'(dif.div_ratio);
        m_p   = 0;
      end
    end else begin
      m_p++;
      if (m_p == m_n) begin
        if (dif.clk_en && dif.div_ratio >= 2) begin
          m_n = int'(dif.div_ratio);
          m_p = 0;
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  function automatic logic exp_level(input logic clk_now);
    if (!m_run) return clk_now;
    return (m_p >= m_n / 2) ? 1'b1 : 1'b0;
  endfunction

  task automatic cycle();
    @(posedge clk);
    step_model();
    #2;
    check_val("div_clk_hi", dif.div_clk, exp_level(clk));
    if (rst_req) begin
      #1 rst_n = 1'b0;
      m_run   = 0;
      rst_req = 0;
      #1 check_val("rst_async", dif.div_clk, clk);
    end
    @(negedge clk);
    #2;
    check_val("div_clk_lo", dif.div_clk, exp_level(clk));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_pos(input int pos);
    int budget;
    budget = 600;
    while (!(m_run && m_p == pos) && budget > 0) begin
      cycle();
      budget--;
    end
    check_val("wait_pos_reached", (m_run && m_p == pos), 1'b1);
  endtask

  task automatic set_in(input bit en, input int ratio);
    dif.clk_en    = en;
    dif.div_ratio = RATIO_WD'(ratio);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_run    = 0;
    m_n      = 0;
    m_p      = 0;
    rst_req  = 0;
    rst_n    = 1'b0;
    set_in(0, 0);

    run(3);
    rst_n = 1'b1;

    set_in(1, 4);
    run(24);
    set_in(1, 5);
    run(50);
    set_in(1, 3);
    run(30);

    set_in(1, 0);
    run(12);
    set_in(1, 1);
    run(10);
    set_in(0, 8);
    run(10);

    set_in(1, 4);
    run_until_pos(1);
    dif.div_ratio = RATIO_WD'(6);
    run(24);

    run_until_pos(3);
    dif.clk_en = 1'b0;
    run(10);

    set_in(1, 255);
    run(600);

    set_in(1, 4);
    run(5);
    run_until_pos(1);
    rst_req = 1;
    cycle();
    run(3);
    rst_n = 1'b1;
    run(20);

    for (int seg = 0; seg < 60; seg++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      r = 0;
      else if (r == 1) r = 1;
      else if (r == 2) r = 255;
      else             r = $urandom_range(2, 17);
      set_in($urandom_range(0, 4) != 0, r);
      if ($urandom_range(0, 9) == 0) rst_req = 1;
      run($urandom_range(1, 40));
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
